alu_cmd_issuer: RTL and testbench

Upstream feeder for the ALU datapath. Buffers operand/command requests in a small FIFO and issues them one at a time to the ALU input pins. Holds each command stable for the ALU latency: LAT cycles normally, MUL_LAT for multiply-class commands. Emits a one-cycle RES_VALID strobe when the ALU outputs for the issued command are due, so the downstream capture stage samples RES/COUT/OFLOW/G/E/L/ERR at the correct edge.

---
 rtl/alu_cmd_issuer.sv | 181 ++++++++++++++++++
 tb/tb_alu_cmd_issuer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_issuer.sv
// ALU command issuer: buffers requests in a small FIFO and holds each one on the ALU pins for its latency.
// Optional ISSUER_FLUSH_EN adds a FLUSH input that empties the FIFO and aborts the in-flight command.
module alu_cmd_issuer #(
  parameter int WIDTH_OP  = 8,
  parameter int WIDTH_CMD = 4,
  parameter int DEPTH     = 4,
  parameter int LAT       = 3,
  parameter int MUL_LAT   = 4
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     REQ_VALID,
  output logic                     REQ_READY,
  input  logic [WIDTH_OP-1:0]      REQ_OPA,
  input  logic [WIDTH_OP-1:0]      REQ_OPB,
  input  logic [WIDTH_CMD-1:0]     REQ_CMD,
  input  logic                     REQ_CIN,
  input  logic                     REQ_MODE,
  input  logic [1:0]               REQ_INP_VALID,
  output logic [WIDTH_OP-1:0]      OPA,
  output logic [WIDTH_OP-1:0]      OPB,
  output logic [WIDTH_CMD-1:0]     CMD,
  output logic                     CIN,
  output logic                     MODE,
  output logic [1:0]               INP_VALID,
  output logic                     CE,
  output logic                     RES_VALID,
  output logic                     BUSY,
`ifdef ISSUER_FLUSH_EN
  input  logic                     FLUSH,
`endif
  output logic [$clog2(DEPTH):0]   COUNT
);

  localparam int PW      = $clog2(DEPTH);
  localparam int CW      = PW + 1;
  localparam int MAX_LAT = (MUL_LAT > LAT) ? MUL_LAT : LAT;
  localparam int WW      = $clog2(MAX_LAT + 1);

  localparam logic [CW-1:0]        CNT_ONE   = CW'(1);
  localparam logic [CW-1:0]        CNT_FULL  = CW'(DEPTH);
  localparam logic [PW-1:0]        PTR_ONE   = PW'(1);
  localparam logic [WW-1:0]        WC_ONE    = WW'(1);
  localparam logic [WW-1:0]        WC_LAT    = WW'(LAT);
  localparam logic [WW-1:0]        WC_MUL    = WW'(MUL_LAT);
  localparam logic [WIDTH_CMD-1:0] CMD_MUL_A = WIDTH_CMD'(9);
  localparam logic [WIDTH_CMD-1:0] CMD_MUL_B = WIDTH_CMD'(10);

  typedef struct packed {
    logic [WIDTH_OP-1:0]  opa;
    logic [WIDTH_OP-1:0]  opb;
    logic [WIDTH_CMD-1:0] cmd;
    logic                 cin;
    logic                 mode;
    logic [1:0]           inp_valid;
  } entry_t;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t         state_reg, state_next;
  logic [WW-1:0]  wait_cnt_reg, wait_cnt_next;
  logic [PW-1:0]  wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]  count_reg, count_next;
  entry_t         mem_reg [DEPTH];
  entry_t         out_reg, head, req_entry;
  logic           res_valid_reg;
  logic           flush, push, issue, done, head_is_mul;
  logic [WW-1:0]  head_lat;

`ifdef ISSUER_FLUSH_EN
  assign flush = FLUSH;
`else
  assign flush = 1'b0;
`endif

  assign req_entry   = '{REQ_OPA, REQ_OPB, REQ_CMD, REQ_CIN, REQ_MODE, REQ_INP_VALID};
  assign head        = mem_reg[rd_ptr_reg];
  assign head_is_mul = head.mode && ((head.cmd == CMD_MUL_A) || (head.cmd == CMD_MUL_B));
  assign head_lat    = head_is_mul ? WC_MUL : WC_LAT;
  assign REQ_READY   = (count_reg < CNT_FULL);
  // A push during FLUSH would land in a FIFO that is being emptied, so drop it.
  assign push        = REQ_VALID && REQ_READY && !flush;

  // FSM: state register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg    <= S_IDLE;
      wait_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
    end
  end

  // FSM: next state; wait_cnt==1 marks the edge on which the result becomes due
  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    issue         = 1'b0;
    done          = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (count_reg != '0) begin
          issue         = 1'b1;
          state_next    = S_WAIT;
          wait_cnt_next = head_lat;
        end
      end
      S_WAIT: begin
        if (wait_cnt_reg == WC_ONE) begin
          done = 1'b1;
          if (count_reg != '0) begin
            issue         = 1'b1;
            wait_cnt_next = head_lat;
          end else begin
            state_next    = S_IDLE;
            wait_cnt_next = '0;
          end
        end else begin
          wait_cnt_next = wait_cnt_reg - WC_ONE;
        end
      end
      default: state_next = S_IDLE;
    endcase
    if (flush) begin
      state_next    = S_IDLE;
      wait_cnt_next = '0;
      issue         = 1'b0;
      done          = 1'b0;
    end
  end

  // FSM: outputs derived from the registered state
  always_comb begin
    BUSY      = (state_reg == S_WAIT);
    CE        = BUSY;
    INP_VALID = BUSY ? out_reg.inp_valid : 2'b00;
  end

  always_comb begin
    count_next = count_reg;
    if (push && !issue)      count_next = count_reg + CNT_ONE;
    else if (!push && issue) count_next = count_reg - CNT_ONE;
  end

  always_ff @(posedge CLK) begin
    if (push) mem_reg[wr_ptr_reg] <= req_entry;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      out_reg       <= '0;
      res_valid_reg <= 1'b0;
    end else begin
      res_valid_reg <= done;
      if (flush) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
        count_reg  <= '0;
      end else begin
        if (push)  wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
        if (issue) rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
        count_reg <= count_next;
      end
      // Operands hold their last values once idle; only INP_VALID/CE drop.
      if (issue) out_reg <= head;
    end
  end

  assign OPA       = out_reg.opa;
  assign OPB       = out_reg.opb;
  assign CMD       = out_reg.cmd;
  assign CIN       = out_reg.cin;
  assign MODE      = out_reg.mode;
  assign RES_VALID = res_valid_reg;
  assign COUNT     = count_reg;

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Directed bench for alu_cmd_issuer (DEPTH=4, LAT=3, MUL_LAT=4); flush steps only with ISSUER_FLUSH_EN.
module tb_alu_cmd_issuer;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       REQ_VALID = 1'b0;
  logic       REQ_READY;
  logic [7:0] REQ_OPA = '0, REQ_OPB = '0;
  logic [3:0] REQ_CMD = '0;
  logic       REQ_CIN = 1'b0, REQ_MODE = 1'b0;
  logic [1:0] REQ_INP_VALID = '0;
  logic [7:0] OPA, OPB;
  logic [3:0] CMD;
  logic       CIN, MODE, CE, RES_VALID, BUSY;
  logic [1:0] INP_VALID;
  logic [2:0] COUNT;
`ifdef ISSUER_FLUSH_EN
  logic       FLUSH = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  alu_cmd_issuer dut (
    .CLK(CLK), .RST(RST),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
    .REQ_OPA(REQ_OPA), .REQ_OPB(REQ_OPB), .REQ_CMD(REQ_CMD),
    .REQ_CIN(REQ_CIN), .REQ_MODE(REQ_MODE), .REQ_INP_VALID(REQ_INP_VALID),
    .OPA(OPA), .OPB(OPB), .CMD(CMD), .CIN(CIN), .MODE(MODE),
    .INP_VALID(INP_VALID), .CE(CE), .RES_VALID(RES_VALID), .BUSY(BUSY),
`ifdef ISSUER_FLUSH_EN
    .FLUSH(FLUSH),
`endif
    .COUNT(COUNT)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] a, input logic [7:0] b, input logic [3:0] c,
                      input logic m, input logic [1:0] iv);
    REQ_VALID = 1'b1; REQ_OPA = a; REQ_OPB = b; REQ_CMD = c;
    REQ_CIN = 1'b0; REQ_MODE = m; REQ_INP_VALID = iv;
  endtask

  initial begin
    logic [7:0] opa_exp;

    // Reset state
    tick(); tick();
    chk("rst_opa", OPA, 0);
    chk("rst_cmd", CMD, 0);
    chk("rst_iv", INP_VALID, 0);
    chk("rst_ce", CE, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_rv", RES_VALID, 0);
    chk("rst_count", COUNT, 0);
    RST = 1'b0;
    tick();
    chk("rdy_after_rst", REQ_READY, 1);

    // Single ADD: push e0, issue e1, RES_VALID after e4
    push(8'h05, 8'h03, 4'd0, 1'b1, 2'b11);
    tick();                                   // e0
    REQ_VALID = 1'b0;
    chk("add_cnt_e0", COUNT, 1);
    chk("add_ce_e0", CE, 0);
    tick();                                   // e1
    chk("add_opa_e1", OPA, 8'h05);
    chk("add_opb_e1", OPB, 8'h03);
    chk("add_ce_e1", CE, 1);
    chk("add_iv_e1", INP_VALID, 2'b11);
    chk("add_busy_e1", BUSY, 1);
    chk("add_cnt_e1", COUNT, 0);
    tick(); chk("add_rv_e2", RES_VALID, 0);
    tick(); chk("add_rv_e3", RES_VALID, 0);
    chk("add_opa_e3", OPA, 8'h05);
    tick();                                   // e4
    chk("add_rv_e4", RES_VALID, 1);
    chk("add_iv_e4", INP_VALID, 0);
    chk("add_ce_e4", CE, 0);
    chk("add_opa_hold", OPA, 8'h05);
    tick(); chk("add_rv_e5", RES_VALID, 0);

    // MUL (MODE=1, CMD=9): RES_VALID after e5
    push(8'h04, 8'h06, 4'd9, 1'b1, 2'b11);
    tick();                                   // e0
    REQ_VALID = 1'b0;
    tick(); chk("mul_cmd_e1", CMD, 9);
    tick(); tick();
    tick(); chk("mul_rv_e4", RES_VALID, 0);
    chk("mul_ce_e4", CE, 1);
    tick(); chk("mul_rv_e5", RES_VALID, 1);
    tick(); chk("mul_rv_e6", RES_VALID, 0);

    // Logical CMD=9 (MODE=0) is not multiply-class: RES_VALID after e4
    push(8'h0F, 8'hF0, 4'd9, 1'b0, 2'b00);
    tick();
    REQ_VALID = 1'b0;
    tick(); chk("log9_iv_e1", INP_VALID, 2'b00);
    chk("log9_ce_e1", CE, 1);
    tick(); tick();
    tick(); chk("log9_rv_e4", RES_VALID, 1);
    tick(); chk("log9_rv_e5", RES_VALID, 0);

    // Fill behind a MUL, fifth push rejected on the full+pop edge, then back-to-back drain
    push(8'h10, 8'h01, 4'd9, 1'b1, 2'b11); tick();   // e0
    push(8'hA1, 8'h01, 4'd0, 1'b1, 2'b11); tick();   // e1
    chk("fill_busy_e1", BUSY, 1);
    push(8'hB2, 8'h01, 4'd0, 1'b1, 2'b11); tick();   // e2
    push(8'hC3, 8'h01, 4'd0, 1'b1, 2'b11); tick();   // e3
    push(8'hD4, 8'h01, 4'd0, 1'b1, 2'b11); tick();   // e4
    chk("full_cnt_e4", COUNT, 4);
    chk("full_rdy_e4", REQ_READY, 0);
    chk("full_rv_e4", RES_VALID, 0);
    push(8'hE5, 8'h01, 4'd0, 1'b1, 2'b11); tick();   // e5
    chk("full_rv_e5", RES_VALID, 1);
    chk("full_cnt_e5", COUNT, 3);
    chk("full_opa_e5", OPA, 8'hA1);
    chk("full_rdy_e5", REQ_READY, 1);
    tick();                                           // e6
    REQ_VALID = 1'b0;
    chk("e_push_cnt_e6", COUNT, 4);
    chk("b2b_rv_e6", RES_VALID, 0);
    for (int e = 7; e <= 21; e++) begin
      tick();
      chk($sformatf("b2b_rv_e%0d", e), RES_VALID,
          (e == 8 || e == 11 || e == 14 || e == 17 || e == 20) ? 1 : 0);
      if (e < 8)       opa_exp = 8'hA1;
      else if (e < 11) opa_exp = 8'hB2;
      else if (e < 14) opa_exp = 8'hC3;
      else if (e < 17) opa_exp = 8'hD4;
      else             opa_exp = 8'hE5;
      chk($sformatf("b2b_opa_e%0d", e), OPA, opa_exp);
      if (e == 17) chk("b2b_cnt_e17", COUNT, 0);
      if (e == 20) begin
        chk("b2b_busy_e20", BUSY, 0);
        chk("b2b_iv_e20", INP_VALID, 0);
      end
    end

    // Reset pulse mid-WAIT with one request still queued
    push(8'h77, 8'h11, 4'd0, 1'b1, 2'b11); tick();   // e0
    push(8'h88, 8'h22, 4'd0, 1'b1, 2'b11); tick();   // e1: issue
    REQ_VALID = 1'b0;
    chk("mrst_busy", BUSY, 1);
    chk("mrst_cnt", COUNT, 1);
    tick();
    #5 RST = 1'b1;
    #2;
    chk("mrst_opa", OPA, 0);
    chk("mrst_ce", CE, 0);
    chk("mrst_busy0", BUSY, 0);
    chk("mrst_cnt0", COUNT, 0);
    chk("mrst_iv", INP_VALID, 0);
    RST = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("mrst_rv_%0d", i), RES_VALID, 0);
      chk($sformatf("mrst_busy_%0d", i), BUSY, 0);
    end

`ifdef ISSUER_FLUSH_EN
    // FLUSH on the completion edge with COUNT=3 and a concurrent push
    push(8'h21, 8'h01, 4'd0, 1'b1, 2'b11); tick();   // e0
    push(8'h32, 8'h01, 4'd0, 1'b1, 2'b11); tick();   // e1
    push(8'h43, 8'h01, 4'd0, 1'b1, 2'b11); tick();   // e2
    push(8'h54, 8'h01, 4'd0, 1'b1, 2'b11); tick();   // e3
    chk("fl_cnt_e3", COUNT, 3);
    chk("fl_busy_e3", BUSY, 1);
    push(8'h65, 8'h01, 4'd0, 1'b1, 2'b11);
    FLUSH = 1'b1;
    tick();                                           // e4
    FLUSH = 1'b0;
    REQ_VALID = 1'b0;
    chk("fl_cnt_e4", COUNT, 0);
    chk("fl_busy_e4", BUSY, 0);
    chk("fl_ce_e4", CE, 0);
    chk("fl_iv_e4", INP_VALID, 0);
    chk("fl_rv_e4", RES_VALID, 0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("fl_rv_%0d", i), RES_VALID, 0);
      chk($sformatf("fl_cnt_%0d", i), COUNT, 0);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
